// File: rtl/cpu_clk_pkg.sv
// -----------------------------------------------------------------------------
// cpu_clk_pkg
// Shared definitions for the CPU clock controller: FSM state type and its
// encodings, plus the default debounce length used by cpu_clk_ctrl and
// btn_sync_edge.
// -----------------------------------------------------------------------------
package cpu_clk_pkg;

    // State encodings are visible on cpu_state, so they are fixed explicitly.
    localparam logic [1:0] ENC_HALT = 2'b00;
    localparam logic [1:0] ENC_RUN  = 2'b01;
    localparam logic [1:0] ENC_STEP = 2'b10;
    localparam logic [1:0] ENC_BRK  = 2'b11;

    typedef enum logic [1:0] {
        ST_HALT = ENC_HALT,
        ST_RUN  = ENC_RUN,
        ST_STEP = ENC_STEP,
        ST_BRK  = ENC_BRK
    } cpu_state_e;

    // Stable clocks the step button needs when debounce is compiled in.
    localparam int DEB_CYCLES_DEF = 16;

endpackage : cpu_clk_pkg

// File: rtl/btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
// Brings the raw single-step button into the clk domain through a two-flop
// synchroniser, optionally debounces it, and emits a one-clk step_ev on each
// rising edge of the resulting level.
//
// Build option: CPU_CLK_DEBOUNCE_EN
//   defined   - level must be stable for DEB_CYCLES clks before it changes.
//   undefined - edge detect acts on the synchronised level (2 clk latency).
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous reset, active low
//   btn      in   raw asynchronous button
//   step_ev  out  registered single-cycle rising-edge event
// -----------------------------------------------------------------------------
module btn_sync_edge
    import cpu_clk_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic step_ev
);

    logic sync1_r;
    logic sync2_r;
    logic lvl_s;        // level the edge detect currently holds
    logic lvl_next_s;   // level that will be held after this clk
    logic step_ev_r;

    // A debounce length below one clk is meaningless; this named empty block
    // shows up in the elaborated hierarchy when that is configured.
    if (DEB_CYCLES < 1) begin : g_deb_cycles_invalid
    end

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

`ifdef CPU_CLK_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [CNT_W-1:0] deb_cnt_r;
    logic             deb_lvl_r;
    logic             deb_flip_s;

    // The level flips on the DEB_CYCLES-th consecutive clk of disagreement.
    assign deb_flip_s = (sync2_r != deb_lvl_r) &&
                        (deb_cnt_r == CNT_W'(DEB_CYCLES - 1));
    assign lvl_next_s = deb_flip_s ? sync2_r : deb_lvl_r;
    assign lvl_s      = deb_lvl_r;

    // Debounce counter and debounced level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt_r <= '0;
            deb_lvl_r <= 1'b0;
        end else begin
            deb_lvl_r <= lvl_next_s;
            if ((sync2_r == deb_lvl_r) || deb_flip_s) begin
                deb_cnt_r <= '0;
            end else begin
                deb_cnt_r <= deb_cnt_r + CNT_W'(1);
            end
        end
    end
`else
    // The synchroniser's second flop is the level; its input is the next level.
    assign lvl_next_s = sync1_r;
    assign lvl_s      = sync2_r;
`endif

    // Edge detect, registered by computing it from the next level so the
    // event lines up with the level change instead of trailing it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_ev_r <= 1'b0;
        end else begin
            step_ev_r <= lvl_next_s & ~lvl_s;
        end
    end

    assign step_ev = step_ev_r;

endmodule : btn_sync_edge

// File: rtl/cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl
// Clock-enable generator for a CPU with free-run, single-step and breakpoint
// modes. A free-running divider supplies a selectable tick; the FSM turns
// ticks into one-clk cpu_en pulses and counts them.
//
// Build option: CPU_CLK_DEBOUNCE_EN (debounce of step_btn, see btn_sync_edge).
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   run_sw     in   level, 1 requests free-run
//   step_btn   in   raw asynchronous single-step button
//   div_sel    in   divider tap select, sampled only in HALT or BRK
//   halt_req   in   breakpoint level from the CPU
//   brk_clr    in   one-clk pulse releasing the breakpoint state
//   clkdiv     out  free-running divider count
//   cpu_en     out  registered one-clk CPU clock enable
//   cpu_state  out  FSM state (HALT=00 RUN=01 STEP=10 BRK=11)
//   cycle_cnt  out  number of cpu_en pulses issued
// -----------------------------------------------------------------------------
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DIV_W      = 32,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic [4:0]       div_sel,
    input  logic             halt_req,
    input  logic             brk_clr,
    output logic [DIV_W-1:0] clkdiv,
    output logic             cpu_en,
    output logic [1:0]       cpu_state,
    output logic [31:0]      cycle_cnt
);

    logic [DIV_W-1:0] clkdiv_r;
    logic [4:0]       sel_q_r;
    logic             tap_r;
    logic             tick_s;
    logic             step_ev_s;
    cpu_state_e       state_r;
    logic             cpu_en_r;
    logic [31:0]      cycle_cnt_r;

    btn_sync_edge #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn     (step_btn),
        .step_ev (step_ev_s)
    );

    // Free-running divider; wraps naturally at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clkdiv_r <= '0;
        end else begin
            clkdiv_r <= clkdiv_r + DIV_W'(1);
        end
    end

    // Tap select is frozen while the CPU is running or stepping so the pulse
    // period cannot change underneath it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q_r <= 5'd0;
        end else if ((state_r == ST_HALT) || (state_r == ST_BRK)) begin
            sel_q_r <= div_sel;
        end else begin
            sel_q_r <= sel_q_r;
        end
    end

    // Delayed copy of the selected tap for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap_r <= 1'b0;
        end else begin
            tap_r <= clkdiv_r[sel_q_r];
        end
    end

    assign tick_s = clkdiv_r[sel_q_r] & ~tap_r;

    // Run-control FSM with registered cpu_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_HALT;
            cpu_en_r <= 1'b0;
        end else begin
            cpu_en_r <= 1'b0;
            case (state_r)
                ST_HALT: begin
                    if (step_ev_s) begin
                        state_r <= ST_STEP;
                    end else if (run_sw && !halt_req) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_HALT;
                    end
                end
                ST_RUN: begin
                    // A tick coinciding with leaving RUN is dropped.
                    if (halt_req) begin
                        state_r <= ST_BRK;
                    end else if (!run_sw) begin
                        state_r <= ST_HALT;
                    end else begin
                        state_r  <= ST_RUN;
                        cpu_en_r <= tick_s;
                    end
                end
                ST_STEP: begin
                    // Pulse is issued while still in STEP; leave on the clk
                    // after, so cpu_en is never seen high in HALT.
                    if (cpu_en_r) begin
                        state_r <= ST_HALT;
                    end else if (tick_s) begin
                        state_r  <= ST_STEP;
                        cpu_en_r <= 1'b1;
                    end else begin
                        state_r <= ST_STEP;
                    end
                end
                ST_BRK: begin
                    if (step_ev_s) begin
                        state_r <= ST_STEP;
                    end else if (brk_clr) begin
                        state_r <= ST_HALT;
                    end else begin
                        state_r <= ST_BRK;
                    end
                end
                default: begin
                    state_r <= ST_HALT;
                end
            endcase
        end
    end

    // Count of issued cpu_en pulses; wraps at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_r <= 32'd0;
        end else if (cpu_en_r) begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    assign clkdiv    = clkdiv_r;
    assign cpu_en    = cpu_en_r;
    assign cpu_state = state_r;
    assign cycle_cnt = cycle_cnt_r;

endmodule : cpu_clk_ctrl

// File: tb/tb_cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_clk_ctrl
// Directed self-checking bench for cpu_clk_ctrl. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cpu_clk_ctrl;

    localparam int DIV_W = 32;
`ifdef CPU_CLK_DEBOUNCE_EN
    localparam int DEB_EXTRA = 16;
`else
    localparam int DEB_EXTRA = 0;
`endif
    // Rising edges from a button rise (on a falling edge) to the FSM reacting.
    localparam int EV_EDGE = 3 + DEB_EXTRA;

    localparam logic [1:0] S_HALT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_BRK  = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic             run_sw;
    logic             step_btn;
    logic [4:0]       div_sel;
    logic             halt_req;
    logic             brk_clr;
    logic [DIV_W-1:0] clkdiv;
    logic             cpu_en;
    logic [1:0]       cpu_state;
    logic [31:0]      cycle_cnt;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int en_seen = 0;

    cpu_clk_ctrl #(
        .DIV_W      (DIV_W),
        .DEB_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .div_sel   (div_sel),
        .halt_req  (halt_req),
        .brk_clr   (brk_clr),
        .clkdiv    (clkdiv),
        .cpu_en    (cpu_en),
        .cpu_state (cpu_state),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cpu_en === 1'b1) en_seen <= en_seen + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_en(input string tag, input int max, output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_en !== 1'b1 && n < max);
        check(tag, 32'(cpu_en), 32'd1);
        at = cyc;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] st, input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_state !== st && n < max);
        check(tag, 32'(cpu_state), 32'(st));
    endtask

    initial begin
        int p1, p2, p3, p4, n;
        logic [1:0] prev;

        // ---------------- reset ----------------
        rst = 1'b0; run_sw = 1'b0; step_btn = 1'b0; div_sel = 5'd2;
        halt_req = 1'b0; brk_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(cpu_state), 32'(S_HALT));
        check("rst_clkdiv", clkdiv, 32'd0);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("clkdiv_count", clkdiv, 32'd5);

        // ---------------- free run, tap 2: period 8 ----------------
        run_sw = 1'b1;
        @(negedge clk);
        check("run_entry", 32'(cpu_state), 32'(S_RUN));
        wait_en("run_p1", 20, p1);
        wait_en("run_p2", 20, p2);
        wait_en("run_p3", 20, p3);
        wait_en("run_p4", 20, p4);
        check("run_period_a", 32'(p2 - p1), 32'd8);
        check("run_period_b", 32'(p3 - p2), 32'd8);
        check("run_period_c", 32'(p4 - p3), 32'd8);
        @(negedge clk);
        check("run_pulse_width", 32'(cpu_en), 32'd0);
        check("run_cycle_cnt4", cycle_cnt, 32'd4);

        // ---------------- div_sel change ignored in RUN ----------------
        div_sel = 5'd4;
        wait_en("div_run_p1", 20, p1);
        wait_en("div_run_p2", 20, p2);
        wait_en("div_run_p3", 20, p3);
        check("div_run_period_a", 32'(p2 - p1), 32'd8);
        check("div_run_period_b", 32'(p3 - p2), 32'd8);
        run_sw = 1'b0;
        @(negedge clk);
        check("run_to_halt", 32'(cpu_state), 32'(S_HALT));
        repeat (3) @(negedge clk);
        run_sw = 1'b1;
        @(negedge clk);
        check("rerun_entry", 32'(cpu_state), 32'(S_RUN));
        wait_en("div4_p1", 80, p1);
        wait_en("div4_p2", 80, p2);
        wait_en("div4_p3", 80, p3);
        check("div4_period_a", 32'(p2 - p1), 32'd32);
        check("div4_period_b", 32'(p3 - p2), 32'd32);
        check("cnt_vs_pulses_a", cycle_cnt, 32'(en_seen));

        // ---------------- breakpoint, step past it ----------------
        halt_req = 1'b1;
        @(negedge clk);
        check("brk_entry", 32'(cpu_state), 32'(S_BRK));
        check("brk_entry_en", 32'(cpu_en), 32'd0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (cpu_en === 1'b1) n++;
        end
        check("brk_no_en", 32'(n), 32'd0);
        step_btn = 1'b1;
        repeat (EV_EDGE - 1) @(negedge clk);
        check("step_latency_pre", 32'(cpu_state), 32'(S_BRK));
        @(negedge clk);
        check("step_latency", 32'(cpu_state), 32'(S_STEP));
        step_btn = 1'b0;
        n = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (cpu_en === 1'b1) n++;
            if (cpu_state === S_HALT) break;
        end
        check("step_one_pulse", 32'(n), 32'd1);
        check("step_to_halt", 32'(cpu_state), 32'(S_HALT));
        check("cnt_vs_pulses_b", cycle_cnt, 32'(en_seen));

        // ---------------- HALT/BRK transitions ----------------
        repeat (2) @(negedge clk);
        check("halt_held_by_req", 32'(cpu_state), 32'(S_HALT));
        halt_req = 1'b0;
        @(negedge clk);
        check("halt_to_run", 32'(cpu_state), 32'(S_RUN));
        halt_req = 1'b1;
        @(negedge clk);
        check("run_to_brk", 32'(cpu_state), 32'(S_BRK));
        brk_clr = 1'b1;
        @(negedge clk);
        brk_clr = 1'b0;
        check("brk_clr_to_halt", 32'(cpu_state), 32'(S_HALT));
        halt_req = 1'b0;
        @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        check("brk_again", 32'(cpu_state), 32'(S_BRK));
        // step_ev and brk_clr reach the FSM on the same clk
        step_btn = 1'b1;
        repeat (EV_EDGE - 1) @(negedge clk);
        brk_clr = 1'b1;
        @(negedge clk);
        brk_clr = 1'b0;
        check("step_beats_brk_clr", 32'(cpu_state), 32'(S_STEP));
        step_btn = 1'b0;
        wait_state("simul_step_done", S_HALT, 80);
        run_sw = 1'b0;
        halt_req = 1'b0;

        // ---------------- cycle_cnt wrap ----------------
        div_sel = 5'd1;
        repeat (30) @(negedge clk);
        force dut.cycle_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt_r;
        check("preload", cycle_cnt, 32'hFFFF_FFFF);
        step_btn = 1'b1;
        wait_state("wrap_step", S_STEP, EV_EDGE + 3);
        step_btn = 1'b0;
        wait_en("wrap_en", 20, p1);
        @(negedge clk);
        check("cycle_cnt_wrap", cycle_cnt, 32'd0);
        check("wrap_halt", 32'(cpu_state), 32'(S_HALT));

        // ---------------- reset during STEP ----------------
        repeat (30) @(negedge clk);
        step_btn = 1'b1;
        wait_state("rst_step", S_STEP, EV_EDGE + 3);
        step_btn = 1'b0;
        wait_en("rst_step_en", 20, p1);
        rst = 1'b0;
        #1;
        check("rst_mid_en", 32'(cpu_en), 32'd0);
        check("rst_mid_state", 32'(cpu_state), 32'(S_HALT));
        check("rst_mid_cnt", cycle_cnt, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (cpu_en === 1'b1) n++;
            if (cpu_state !== S_HALT) n++;
        end
        check("post_rst_quiet", 32'(n), 32'd0);
        check("post_rst_clkdiv", clkdiv, 32'd30);

`ifdef CPU_CLK_DEBOUNCE_EN
        // ---------------- debounce ----------------
        step_btn = 1'b1;
        repeat (10) @(negedge clk);
        step_btn = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (cpu_state !== S_HALT) n++;
        end
        check("glitch_ignored", 32'(n), 32'd0);
        step_btn = 1'b1;
        n = 0;
        prev = S_HALT;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 20) step_btn = 1'b0;
            if (cpu_state === S_STEP && prev !== S_STEP) n++;
            prev = cpu_state;
        end
        check("press_one_step", 32'(n), 32'd1);
`else
        prev = S_HALT;
        check("prev_unused_state", 32'(cpu_state), 32'(prev));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cpu_clk_ctrl

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 32: width of the internal divider counter.
REQ-002 SHALL have parameter DEB_CYCLES, default 16: number of stable cycles step_btn needs when debounce is compiled in.
REQ-003 SHALL have port clk  input  1: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port run_sw  input  1: level; 1 requests free-run.
REQ-006 SHALL have port step_btn  input  1: raw, asynchronous single-step button.
REQ-007 SHALL have port div_sel  input  5: selects divider tap clkdiv[div_sel].
REQ-008 SHALL have port halt_req  input  1: level from CPU (breakpoint); stops free-run.
REQ-009 SHALL have port brk_clr  input  1: one-cycle pulse; releases the breakpoint state.
REQ-010 SHALL have port clkdiv  output  DIV_W: free-running divider count.
REQ-011 SHALL have port cpu_en  output  1: one-clk-wide CPU clock-enable pulse.
REQ-012 SHALL have port cpu_state  output  2: current FSM state.
REQ-013 SHALL have port cycle_cnt  output  32: count of cpu_en pulses issued.

Function
REQ-014 clkdiv SHALL increment by 1 every clk and wrap from all-ones to 0.
REQ-015 div_sel SHALL be latched into sel_q only in HALT or BRK; changes in RUN or STEP SHALL be ignored.
REQ-016 tick SHALL be 1 when clkdiv[sel_q] is 1 and its registered copy is 0. With sel_q=k, one tick occurs every 2^(k+1) clks.
REQ-017 step_btn SHALL pass through a 2-flop synchroniser, then a rising-edge detect, giving a single-cycle step_ev.
REQ-018 FSM states and encodings: HALT=00, RUN=01, STEP=10, BRK=11; cpu_state SHALL equal the state register.
REQ-019 HALT transitions, in priority order: step_ev -> STEP; otherwise run_sw=1 and halt_req=0 -> RUN; otherwise stay.
REQ-020 RUN transitions, in priority order: halt_req=1 -> BRK; otherwise run_sw=0 -> HALT.
REQ-021 STEP: on the first tick, issue one cpu_en and go to HALT; run_sw and step_ev SHALL be ignored while in STEP.
REQ-022 BRK transitions, in priority order: step_ev -> STEP (step past breakpoint); otherwise brk_clr -> HALT. A simultaneous step_ev and brk_clr SHALL go to STEP.
REQ-023 cpu_en SHALL be registered and asserted the clk after a tick while the state is RUN, or while it is STEP (single pulse); it SHALL never be 1 in HALT or BRK.
REQ-024 A tick in the same cycle as a RUN->BRK or RUN->HALT transition SHALL NOT produce cpu_en.
REQ-025 cycle_cnt SHALL increment on each cpu_en and wrap from 0xFFFFFFFF to 0.

Reset
REQ-026 rst=0 SHALL asynchronously force: state=HALT, clkdiv=0, cpu_en=0, cycle_cnt=0, sel_q=0, synchroniser and edge flops=0, debounce counter=0.
REQ-027 Reset asserted mid-RUN or mid-STEP SHALL abort with no further cpu_en; after release the FSM SHALL start in HALT.

Configuration
REQ-028 Macro CPU_CLK_DEBOUNCE_EN defined: the synchronised button SHALL be stable for DEB_CYCLES consecutive clks before its debounced level changes; the edge detect SHALL act on the debounced level.
REQ-029 Macro CPU_CLK_DEBOUNCE_EN undefined: the edge detect SHALL act directly on the synchronised level, with 2 clk latency from a clean step_btn rise to step_ev.

Structure
REQ-030 Package cpu_clk_pkg SHALL hold the state typedef, the four state encodings and the default DEB_CYCLES constant.
REQ-031 Sub-module btn_sync_edge SHALL contain the synchroniser, the optional debounce and the edge detect, and output step_ev.

Verification
REQ-032 Reset, div_sel=2, run_sw=1: state RUN; cpu_en pulses exactly every 8 clks; cycle_cnt=4 after 4 pulses.
REQ-033 In RUN, assert halt_req: state BRK next clk; no cpu_en. Pulse step_btn: exactly one cpu_en, then HALT; cycle_cnt +1.
REQ-034 In BRK, assert step_ev and brk_clr in the same clk: next state STEP, not HALT.
REQ-035 Change div_sel 2->4 in RUN: period stays 8 clks; after run_sw=0 then run_sw=1 again, period is 32 clks.
REQ-036 Preload cycle_cnt=0xFFFFFFFF (force), one cpu_en: cycle_cnt=0. Assert rst=0 mid-STEP: cpu_en=0 immediately; HALT after release.
REQ-037 With CPU_CLK_DEBOUNCE_EN defined, a 10-clk glitch on step_btn: no step_ev; a 20-clk press: exactly one step_ev.
